// File: rtl/dump_configs.sv
// Readback transmitter: serialises the configuration store, selects and pulse shape into a byte frame for the UART.
// Optional feature: define CHECKSUM_EN to append an XOR checksum byte to every frame.
module dump_configs #(
    parameter logic [7:0] HEADER    = 8'hA5,
    parameter int         NUM_CH    = 8,
    parameter int         NUM_ALINE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dump_req,
    input  logic        intaking_configs,
    output logic [6:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    input  logic [7:0]  channel_select,
    input  logic [4:0]  aline_select,
    input  logic [31:0] pulse_shape,
    output logic [7:0]  tx_byte,
    output logic        tx_send,
    input  logic        tx_busy,
    output logic        dumping,
    output logic        dump_done
);

    // Byte index layout: 0 header, 1..2*words store bytes (odd = MSB), then selects and pulse shape.
    localparam logic [8:0] IDX_WORD_LAST = 9'(2 * NUM_CH * NUM_ALINE);
    localparam logic [8:0] IDX_CHSEL     = IDX_WORD_LAST + 9'd1;
    localparam logic [8:0] IDX_ALSEL     = IDX_WORD_LAST + 9'd2;
    localparam logic [8:0] IDX_PULSE     = IDX_WORD_LAST + 9'd3;
`ifdef CHECKSUM_EN
    localparam logic [8:0] IDX_LAST      = IDX_PULSE + 9'd4;
`else
    localparam logic [8:0] IDX_LAST      = IDX_PULSE + 9'd3;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, FETCH, SEND, HOLD, WAIT} state_t;

    state_t      state;
    state_t      next_state;
    logic [8:0]  byte_idx;
    logic [8:0]  next_idx;
    logic [7:0]  word_lsb;
    logic [7:0]  load_byte;
    logic        is_word;
    logic        is_msb;
    logic        next_is_msb;
    logic        accept;
    logic        advance;
    logic        last_byte;
`ifdef CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    assign is_word     = (byte_idx >= 9'd1) && (byte_idx <= IDX_WORD_LAST);
    assign is_msb      = is_word && byte_idx[0];
    assign next_idx    = byte_idx + 9'd1;
    assign next_is_msb = (next_idx >= 9'd1) && (next_idx <= IDX_WORD_LAST) && next_idx[0];
    assign accept      = (state == IDLE) && dump_req && !intaking_configs;
    // A transmitter that never raised tx_busy during HOLD is treated as having taken the byte already.
    assign advance     = ((state == HOLD) || (state == WAIT)) && !tx_busy;
    assign last_byte   = (byte_idx == IDX_LAST);

    always_comb begin
        load_byte = HEADER;
        if (is_word) begin
            load_byte = word_lsb;
        end else if (byte_idx == IDX_CHSEL) begin
            load_byte = channel_select;
        end else if (byte_idx == IDX_ALSEL) begin
            load_byte = {3'b000, aline_select};
        end else if (byte_idx == IDX_PULSE) begin
            load_byte = pulse_shape[31:24];
        end else if (byte_idx == IDX_PULSE + 9'd1) begin
            load_byte = pulse_shape[23:16];
        end else if (byte_idx == IDX_PULSE + 9'd2) begin
            load_byte = pulse_shape[15:8];
        end else if (byte_idx == IDX_PULSE + 9'd3) begin
            load_byte = pulse_shape[7:0];
`ifdef CHECKSUM_EN
        end else if (byte_idx == IDX_LAST) begin
            load_byte = checksum;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = LOAD;
            LOAD:    next_state = is_msb ? FETCH : SEND;
            FETCH:   next_state = SEND;
            SEND:    next_state = HOLD;
            HOLD,
            WAIT: begin
                if (tx_busy) begin
                    next_state = WAIT;
                end else begin
                    next_state = last_byte ? IDLE : LOAD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // cfg_addr is set on entry to LOAD so the registered store read lands during FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_addr  <= 7'd0;
            tx_byte   <= 8'd0;
            tx_send   <= 1'b0;
            dumping   <= 1'b0;
            dump_done <= 1'b0;
            byte_idx  <= 9'd0;
            word_lsb  <= 8'd0;
`ifdef CHECKSUM_EN
            checksum  <= 8'd0;
`endif
        end else begin
            tx_send   <= 1'b0;
            dump_done <= 1'b0;
            if (accept) begin
                dumping  <= 1'b1;
                byte_idx <= 9'd0;
`ifdef CHECKSUM_EN
                checksum <= 8'd0;
`endif
            end
            if (advance && !last_byte) begin
                byte_idx <= next_idx;
                if (next_is_msb) begin
                    cfg_addr <= next_idx[7:1];
                end
            end
            if (advance && last_byte) begin
                dumping   <= 1'b0;
                dump_done <= 1'b1;
            end
            case (state)
                LOAD: begin
                    if (!is_msb) begin
                        tx_byte <= load_byte;
                        tx_send <= 1'b1;
                    end
                end
                // The MSB goes straight out; only the LSB is kept for the following byte.
                FETCH: begin
                    tx_byte  <= cfg_data[15:8];
                    word_lsb <= cfg_data[7:0];
                    tx_send  <= 1'b1;
                end
`ifdef CHECKSUM_EN
                SEND: checksum <= checksum ^ tx_byte;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dump_configs.sv
// Bench for dump_configs: store and UART models, expected frame queued at request, bytes compared per scenario.
module tb_dump_configs;

`ifdef CHECKSUM_EN
    localparam int FRAME_LEN = 264;
`else
    localparam int FRAME_LEN = 263;
`endif
    localparam int TIMEOUT = 8000;

    logic        clk = 1'b0;
    logic        rst;
    logic        dump_req;
    logic        intaking_configs;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [7:0]  channel_select;
    logic [4:0]  aline_select;
    logic [31:0] pulse_shape;
    logic [7:0]  tx_byte;
    logic        tx_send;
    logic        tx_busy;
    logic        dumping;
    logic        dump_done;

    logic [15:0] mem [128];
    logic        busy_en;
    int          busy_cnt;
    int          cycle;
    int          n_checks;
    int          n_fails;
    logic [7:0]  exp_q[$];
    logic [7:0]  obs_q[$];
    int          obs_t[$];
    logic [6:0]  obs_a[$];
    int          done_cnt;
    int          dump_bad;
    int          dump_hi_cnt;
    int          req_t;
    logic        dumping_after_req;
    bit          timed_out;

    always #5 clk = ~clk;

    dump_configs dut (
        .clk              (clk),
        .rst              (rst),
        .dump_req         (dump_req),
        .intaking_configs (intaking_configs),
        .cfg_addr         (cfg_addr),
        .cfg_data         (cfg_data),
        .channel_select   (channel_select),
        .aline_select     (aline_select),
        .pulse_shape      (pulse_shape),
        .tx_byte          (tx_byte),
        .tx_send          (tx_send),
        .tx_busy          (tx_busy),
        .dumping          (dumping),
        .dump_done        (dump_done)
    );

    always @(posedge clk) cycle++;

    // Registered-read store model
    always @(posedge clk) cfg_data <= mem[cfg_addr];

    // UART model: busy for 10 cycles per byte when enabled
    always @(posedge clk or posedge rst) begin
        if (rst) busy_cnt <= 0;
        else if (busy_en && tx_send) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_send) begin
                obs_q.push_back(tx_byte);
                obs_t.push_back(cycle);
                obs_a.push_back(cfg_addr);
                if (!dumping) dump_bad++;
            end
            if (dump_done) begin
                done_cnt++;
                if (dumping) dump_bad++;
            end
            if (dumping) dump_hi_cnt++;
        end
    end

    task automatic push_frame();
        logic [7:0] sum;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int a = 0; a < 128; a++) begin
            exp_q.push_back(mem[a][15:8]);
            exp_q.push_back(mem[a][7:0]);
        end
        exp_q.push_back(channel_select);
        exp_q.push_back({3'b000, aline_select});
        exp_q.push_back(pulse_shape[31:24]);
        exp_q.push_back(pulse_shape[23:16]);
        exp_q.push_back(pulse_shape[15:8]);
        exp_q.push_back(pulse_shape[7:0]);
`ifdef CHECKSUM_EN
        sum = 8'h00;
        foreach (exp_q[i]) sum ^= exp_q[i];
        exp_q.push_back(sum);
`endif
    endtask

    task automatic clear_obs();
        @(posedge clk);
        #1;
        obs_q.delete();
        obs_t.delete();
        obs_a.delete();
        done_cnt    = 0;
        dump_bad    = 0;
        dump_hi_cnt = 0;
    endtask

    task automatic pulse_req();
        @(negedge clk);
        dump_req = 1'b1;
        req_t    = cycle;
        @(negedge clk);
        dump_req = 1'b0;
        dumping_after_req = dumping;
    endtask

    task automatic start_frame();
        clear_obs();
        push_frame();
        pulse_req();
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0) begin
                to = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic load_pattern();
        for (int a = 0; a < 128; a++) mem[a] = {1'b0, 7'(a), 8'h3C};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (cfg_addr !== 7'd0) begin n_fails++; $display("[TB] FAIL reset_cfg_addr got %h expected 00", cfg_addr); end
        n_checks++; if (tx_byte !== 8'd0) begin n_fails++; $display("[TB] FAIL reset_tx_byte got %h expected 00", tx_byte); end
        n_checks++; if (tx_send !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_tx_send got %b expected 0", tx_send); end
        n_checks++; if (dumping !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_dumping got %b expected 0", dumping); end
        n_checks++; if (dump_done !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_dump_done got %b expected 0", dump_done); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_frame();
        logic [7:0] trail [6];
        trail = '{8'h81, 8'h1F, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load_pattern();
        channel_select = 8'h81;
        aline_select   = 5'h1F;
        pulse_shape    = 32'hDEADBEEF;
        busy_en        = 1'b1;
        start_frame();
        wait_done(timed_out);
        n_checks++; if (timed_out !== 1'b0) begin n_fails++; $display("[TB] FAIL full_timeout got %b expected 0", timed_out); end
        n_checks++; if (dumping_after_req !== 1'b1) begin n_fails++; $display("[TB] FAIL full_dumping_rise got %b expected 1", dumping_after_req); end
        n_checks++; if (obs_q.size() !== FRAME_LEN) begin n_fails++; $display("[TB] FAIL full_len got %0d expected %0d", obs_q.size(), FRAME_LEN); end
        if (obs_q.size() > 0) begin
            n_checks++; if (obs_t[0] - req_t !== 2) begin n_fails++; $display("[TB] FAIL full_latency got %0d expected 2", obs_t[0] - req_t); end
        end
        for (int i = 0; i < FRAME_LEN && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fails++; $display("[TB] FAIL full_byte[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 0; i < 6 && 257 + i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[257 + i] !== trail[i]) begin n_fails++; $display("[TB] FAIL trail_byte[%0d] got %h expected %h", i, obs_q[257 + i], trail[i]); end
        end
        n_checks++; if (done_cnt !== 1) begin n_fails++; $display("[TB] FAIL full_done_count got %0d expected 1", done_cnt); end
        n_checks++; if (dump_bad !== 0) begin n_fails++; $display("[TB] FAIL full_dumping_window got %0d expected 0", dump_bad); end
        n_checks++; if (dumping !== 1'b0) begin n_fails++; $display("[TB] FAIL full_dumping_end got %b expected 0", dumping); end
    endtask

    task automatic test_zero_frame();
        logic [7:0] last_exp;
`ifdef CHECKSUM_EN
        last_exp = 8'hA5;
`else
        last_exp = 8'h00;
`endif
        for (int a = 0; a < 128; a++) mem[a] = 16'h0000;
        channel_select = 8'h00;
        aline_select   = 5'h00;
        pulse_shape    = 32'h0;
        busy_en        = 1'b1;
        start_frame();
        wait_done(timed_out);
        n_checks++; if (timed_out !== 1'b0) begin n_fails++; $display("[TB] FAIL zero_timeout got %b expected 0", timed_out); end
        n_checks++; if (obs_q.size() !== FRAME_LEN) begin n_fails++; $display("[TB] FAIL zero_len got %0d expected %0d", obs_q.size(), FRAME_LEN); end
        if (obs_q.size() > 0) begin
            n_checks++; if (obs_q[obs_q.size() - 1] !== last_exp) begin n_fails++; $display("[TB] FAIL zero_last_byte got %h expected %h", obs_q[obs_q.size() - 1], last_exp); end
        end
        for (int i = 0; i < FRAME_LEN && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fails++; $display("[TB] FAIL zero_byte[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_ignore();
        bit hit;
        load_pattern();
        channel_select = 8'h5A;
        aline_select   = 5'h0C;
        pulse_shape    = 32'h12345678;
        busy_en        = 1'b1;
        clear_obs();
        intaking_configs = 1'b1;
        pulse_req();
        repeat (20) @(negedge clk);
        intaking_configs = 1'b0;
        n_checks++; if (obs_q.size() !== 0) begin n_fails++; $display("[TB] FAIL intake_tx_send got %0d expected 0", obs_q.size()); end
        n_checks++; if (dump_hi_cnt !== 0) begin n_fails++; $display("[TB] FAIL intake_dumping got %0d expected 0", dump_hi_cnt); end

        start_frame();
        hit = 1'b0;
        for (int i = 0; i < TIMEOUT && !hit; i++) begin
            @(negedge clk);
            #1;
            if (obs_q.size() >= 50) hit = 1'b1;
        end
        n_checks++; if (hit !== 1'b1) begin n_fails++; $display("[TB] FAIL mid_reach_byte50 got %b expected 1", hit); end
        pulse_req();
        wait_done(timed_out);
        repeat (40) @(negedge clk);
        n_checks++; if (timed_out !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_timeout got %b expected 0", timed_out); end
        n_checks++; if (obs_q.size() !== FRAME_LEN) begin n_fails++; $display("[TB] FAIL mid_len got %0d expected %0d", obs_q.size(), FRAME_LEN); end
        n_checks++; if (done_cnt !== 1) begin n_fails++; $display("[TB] FAIL mid_done_count got %0d expected 1", done_cnt); end
        for (int i = 0; i < FRAME_LEN && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fails++; $display("[TB] FAIL mid_byte[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        bit hit;
        load_pattern();
        channel_select = 8'h33;
        aline_select   = 5'h11;
        pulse_shape    = 32'hCAFE0042;
        busy_en        = 1'b1;
        start_frame();
        hit = 1'b0;
        for (int i = 0; i < TIMEOUT && !hit; i++) begin
            @(negedge clk);
            #1;
            if (obs_q.size() >= 100) hit = 1'b1;
        end
        n_checks++; if (hit !== 1'b1) begin n_fails++; $display("[TB] FAIL rst_reach_byte100 got %b expected 1", hit); end
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (cfg_addr !== 7'd0) begin n_fails++; $display("[TB] FAIL rst_mid_cfg_addr got %h expected 00", cfg_addr); end
        n_checks++; if (tx_byte !== 8'd0) begin n_fails++; $display("[TB] FAIL rst_mid_tx_byte got %h expected 00", tx_byte); end
        n_checks++; if (tx_send !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_mid_tx_send got %b expected 0", tx_send); end
        n_checks++; if (dumping !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_mid_dumping got %b expected 0", dumping); end
        n_checks++; if (dump_done !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_mid_dump_done got %b expected 0", dump_done); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start_frame();
        wait_done(timed_out);
        n_checks++; if (timed_out !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_new_timeout got %b expected 0", timed_out); end
        n_checks++; if (obs_q.size() !== FRAME_LEN) begin n_fails++; $display("[TB] FAIL rst_new_len got %0d expected %0d", obs_q.size(), FRAME_LEN); end
        if (obs_q.size() > 0) begin
            n_checks++; if (obs_q[0] !== 8'hA5) begin n_fails++; $display("[TB] FAIL rst_new_header got %h expected a5", obs_q[0]); end
        end
        for (int i = 0; i < FRAME_LEN && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fails++; $display("[TB] FAIL rst_new_byte[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int gap_exp;
        load_pattern();
        channel_select = 8'h81;
        aline_select   = 5'h1F;
        pulse_shape    = 32'hDEADBEEF;
        busy_en        = 1'b0;
        start_frame();
        wait_done(timed_out);
        n_checks++; if (timed_out !== 1'b0) begin n_fails++; $display("[TB] FAIL b2b_timeout got %b expected 0", timed_out); end
        n_checks++; if (obs_q.size() !== FRAME_LEN) begin n_fails++; $display("[TB] FAIL b2b_len got %0d expected %0d", obs_q.size(), FRAME_LEN); end
        for (int i = 1; i < obs_q.size(); i++) begin
            gap_exp = ((i % 2 == 1) && (i <= 255)) ? 4 : 3;
            n_checks++;
            if (obs_t[i] - obs_t[i - 1] !== gap_exp) begin n_fails++; $display("[TB] FAIL b2b_gap[%0d] got %0d expected %0d", i, obs_t[i] - obs_t[i - 1], gap_exp); end
            if (gap_exp == 4) begin
                n_checks++;
                if (obs_a[i] !== 7'((i - 1) / 2)) begin n_fails++; $display("[TB] FAIL b2b_addr[%0d] got %0d expected %0d", i, obs_a[i], (i - 1) / 2); end
            end
        end
        for (int i = 0; i < FRAME_LEN && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fails++; $display("[TB] FAIL b2b_byte[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        rst              = 1'b1;
        dump_req         = 1'b0;
        intaking_configs = 1'b0;
        channel_select   = 8'h00;
        aline_select     = 5'h00;
        pulse_shape      = 32'h0;
        busy_en          = 1'b0;
        n_checks         = 0;
        n_fails          = 0;
        for (int a = 0; a < 128; a++) mem[a] = 16'h0000;
        test_reset();
        test_full_frame();
        test_zero_frame();
        test_ignore();
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
